// File: rtl/vpu_tile_seq_pkg.sv
// ==== vpu_tile_seq_pkg : shared defaults, loop-order codes and FSM encoding ====
// ==== rev 1.0 ==================================================================
`default_nettype none

package vpu_tile_seq_pkg;

  localparam int unsigned VPU_MAX_DIM = 64;
  localparam int unsigned VPU_TILE    = 4;

  localparam logic ORDER_IJK = 1'b0;
  localparam logic ORDER_KIJ = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  function automatic logic cnt_legal(input int unsigned c, input int unsigned max_tiles);
    return (c != 0) && (c <= max_tiles);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vpu_tile_ctr.sv
// ==== vpu_tile_ctr : tile counter that wraps at limit-1 and flags the carry ====
// ==== rev 1.0 ==================================================================
`default_nettype none

module vpu_tile_ctr #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign wrap = inc & (cnt_q == (limit - CNT_W'(1)));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || wrap) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vpu_tile_seq.sv
// ==== vpu_tile_seq : runtime tile-loop sequencer with valid/ready tuple output ====
// ==== rev 1.0 =====================================================================
`default_nettype none

module vpu_tile_seq
  import vpu_tile_seq_pkg::*;
#(
  parameter int unsigned MAX_DIM = VPU_MAX_DIM,
  parameter int unsigned TILE    = VPU_TILE,
  parameter int unsigned IDX_W   = $clog2(MAX_DIM),
  parameter int unsigned CNT_W   = $clog2(MAX_DIM / TILE) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_mt,
  input  logic [CNT_W-1:0] cfg_nt,
  input  logic [CNT_W-1:0] cfg_kt,
  input  logic             cfg_order,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic [IDX_W-1:0] index_i,
  output logic [IDX_W-1:0] index_j,
  output logic [IDX_W-1:0] index_k,
  output logic             first_k,
  output logic             last_k,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned TILE_SH   = $clog2(TILE);
  localparam int unsigned MAX_TILES = MAX_DIM / TILE;

  state_e           state_q;
  logic [CNT_W-1:0] mt_q, nt_q, kt_q;
  logic             order_q;
  logic             valid_q, busy_q, done_q, err_q;

  logic [CNT_W-1:0] cnt_i, cnt_j, cnt_k;
  logic             wrap_i, wrap_j, wrap_k;
  logic             inc_i, inc_j, inc_k;
  logic             hs, ctr_clr, cfg_ok, at_last;

  function automatic logic [IDX_W-1:0] to_idx(input logic [CNT_W-1:0] c);
    logic [IDX_W+CNT_W-1:0] w;
    w = {{IDX_W{1'b0}}, c} << TILE_SH;
    return w[IDX_W-1:0];
  endfunction

  // idx_valid is only ever high in RUN, so it stands in for the state check.
  assign hs      = valid_q & idx_ready & ~abort;
  assign ctr_clr = abort | ((state_q == ST_IDLE) & start);
  assign cfg_ok  = cnt_legal(32'(cfg_mt), MAX_TILES) &
                   cnt_legal(32'(cfg_nt), MAX_TILES) &
                   cnt_legal(32'(cfg_kt), MAX_TILES);
  assign at_last = (cnt_i == mt_q - CNT_W'(1)) &
                   (cnt_j == nt_q - CNT_W'(1)) &
                   (cnt_k == kt_q - CNT_W'(1));

  // Carry chain: i-j-k steps k first; k-i-j steps j first and k last.
  always_comb begin
    inc_i = 1'b0;
    inc_j = 1'b0;
    inc_k = 1'b0;
    if (order_q == ORDER_IJK) begin
      inc_k = hs;
      inc_j = wrap_k;
      inc_i = wrap_j;
    end else begin
      inc_j = hs;
      inc_i = wrap_j;
      inc_k = wrap_i;
    end
  end

  vpu_tile_ctr #(.CNT_W(CNT_W)) u_ctr_i (
    .clk(clk), .reset_n(reset_n), .clr(ctr_clr), .inc(inc_i),
    .limit(mt_q), .cnt(cnt_i), .wrap(wrap_i)
  );

  vpu_tile_ctr #(.CNT_W(CNT_W)) u_ctr_j (
    .clk(clk), .reset_n(reset_n), .clr(ctr_clr), .inc(inc_j),
    .limit(nt_q), .cnt(cnt_j), .wrap(wrap_j)
  );

  vpu_tile_ctr #(.CNT_W(CNT_W)) u_ctr_k (
    .clk(clk), .reset_n(reset_n), .clr(ctr_clr), .inc(inc_k),
    .limit(kt_q), .cnt(cnt_k), .wrap(wrap_k)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mt_q    <= '0;
      nt_q    <= '0;
      kt_q    <= '0;
      order_q <= ORDER_IJK;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort) begin
        state_q <= ST_IDLE;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              mt_q    <= cfg_mt;
              nt_q    <= cfg_nt;
              kt_q    <= cfg_kt;
              order_q <= cfg_order;
              busy_q  <= 1'b1;
              if (cfg_ok) begin
                state_q <= ST_RUN;
                valid_q <= 1'b1;
              end else begin
                state_q <= ST_FIN;
                done_q  <= 1'b1;
                err_q   <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (hs && at_last) begin
              state_q <= ST_FIN;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          ST_FIN: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign idx_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign index_i   = to_idx(cnt_i);
  assign index_j   = to_idx(cnt_j);
  assign index_k   = to_idx(cnt_k);
  assign first_k   = valid_q & (cnt_k == '0);
  assign last_k    = valid_q & (cnt_k == kt_q - CNT_W'(1));
  assign last      = valid_q & at_last;

endmodule

`default_nettype wire

// File: tb/tb_vpu_tile_seq.sv
// ==== tb_vpu_tile_seq : directed bench with a loop-nest reference model ====
// ==== rev 1.0 ==============================================================
`default_nettype none

module tb_vpu_tile_seq;

  localparam int TILE = 4;
  localparam int MAXT = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] cfg_mt = '0, cfg_nt = '0, cfg_kt = '0;
  logic       cfg_order = 1'b0;
  logic       idx_ready = 1'b0;
  logic       idx_valid, first_k, last_k, last, busy, done, err;
  logic [5:0] index_i, index_j, index_k;

  vpu_tile_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .cfg_mt(cfg_mt), .cfg_nt(cfg_nt), .cfg_kt(cfg_kt), .cfg_order(cfg_order),
    .idx_valid(idx_valid), .idx_ready(idx_ready),
    .index_i(index_i), .index_j(index_j), .index_k(index_k),
    .first_k(first_k), .last_k(last_k), .last(last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int i; int j; int k;
    bit fk; bit lk; bit ls;
    int cyc;
  } tup_t;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  tup_t q[$];
  tup_t lg[$];
  bit   m_busy = 0, m_done = 0, m_err = 0;
  int   cyc = 0, hs_count = 0, done_count = 0, done_cyc = 0, valid_cycles = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input int c);
    return (c >= 1) && (c <= MAXT);
  endfunction

  // Reference: the tile loop nest written out directly for each order.
  task automatic build(input int mt, input int nt, input int kt, input bit order);
    tup_t t;
    q.delete();
    t.cyc = 0;
    if (order == 1'b0) begin
      for (int i = 0; i < mt; i++)
        for (int j = 0; j < nt; j++)
          for (int k = 0; k < kt; k++) begin
            t.i = i * TILE; t.j = j * TILE; t.k = k * TILE;
            t.fk = (k == 0); t.lk = (k == kt - 1); t.ls = 1'b0;
            q.push_back(t);
          end
    end else begin
      for (int k = 0; k < kt; k++)
        for (int i = 0; i < mt; i++)
          for (int j = 0; j < nt; j++) begin
            t.i = i * TILE; t.j = j * TILE; t.k = k * TILE;
            t.fk = (k == 0); t.lk = (k == kt - 1); t.ls = 1'b0;
            q.push_back(t);
          end
    end
    q[q.size() - 1].ls = 1'b1;
  endtask

  task automatic model_reset();
    q.delete();
    m_busy = 0; m_done = 0; m_err = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      bit   n_done, n_err;
      tup_t e, a;
      cyc++;
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_done));
      chk("err", int'(err), int'(m_err));
      chk("idx_valid", int'(idx_valid), int'(q.size() > 0));
      if (q.size() > 0) begin
        e = q[0];
        chk("index_i", int'(index_i), e.i);
        chk("index_j", int'(index_j), e.j);
        chk("index_k", int'(index_k), e.k);
        chk("first_k", int'(first_k), int'(e.fk));
        chk("last_k", int'(last_k), int'(e.lk));
        chk("last", int'(last), int'(e.ls));
      end else begin
        chk("flags_idle", int'({first_k, last_k, last}), 0);
      end
      if (idx_valid) valid_cycles++;
      if (done) begin done_count++; done_cyc = cyc; end
      if (idx_valid && idx_ready && !abort) begin
        a.i = int'(index_i); a.j = int'(index_j); a.k = int'(index_k);
        a.fk = first_k; a.lk = last_k; a.ls = last; a.cyc = cyc;
        lg.push_back(a);
        hs_count++;
      end
      n_done = 0; n_err = 0;
      if (abort) begin
        q.delete();
        m_busy = 0;
      end else if (!m_busy && start) begin
        m_busy = 1;
        if (legal(int'(cfg_mt)) && legal(int'(cfg_nt)) && legal(int'(cfg_kt)))
          build(int'(cfg_mt), int'(cfg_nt), int'(cfg_kt), cfg_order);
        else begin
          n_done = 1; n_err = 1;
        end
      end else if (q.size() > 0 && idx_ready) begin
        e = q.pop_front();
        if (e.ls) n_done = 1;
      end else if (m_done) begin
        m_busy = 0;
      end
      m_done = n_done;
      m_err  = n_err;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int mt, input int nt, input int kt, input bit order);
    start = 1'b1;
    cfg_mt = 5'(mt); cfg_nt = 5'(nt); cfg_kt = 5'(kt); cfg_order = order;
    tick();
    start = 1'b0;
    cfg_mt = 5'd31; cfg_nt = 5'd0; cfg_kt = 5'd3; cfg_order = ~order;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    d0 = done_count;
    for (int n = 0; n < budget && done_count == d0; n++) tick();
    chk(name, int'(done_count != d0), 1);
    tick();
    tick();
  endtask

  initial begin
    int d0, v0;
    int seen[int];
    int dups, key;

    repeat (2) @(posedge clk);
    #2;
    chk("rst_outputs", int'({idx_valid, first_k, last_k, last, busy, done, err}), 0);
    chk("rst_index", int'({index_i, index_j, index_k}), 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    tick();
    tick();

    // mt=nt=kt=2, order i-j-k, ready held high
    idx_ready = 1'b1;
    lg.delete();
    do_start(2, 2, 2, 1'b0);
    wait_done("t1_done_timeout", 40);
    chk("t1_hs", lg.size(), 8);
    if (lg.size() == 8) begin
      chk("t1_tuple1_k", lg[1].k, 4);
      chk("t1_tuple2_j", lg[2].j, 4);
      chk("t1_tuple2_k", lg[2].k, 0);
      chk("t1_tuple7_ijk", lg[7].i + lg[7].j + lg[7].k, 12);
      chk("t1_last7", int'(lg[7].ls), 1);
      chk("t1_first_k0", int'(lg[0].fk), 1);
      chk("t1_last_k1", int'(lg[1].lk), 1);
      chk("t1_back_to_back", lg[7].cyc - lg[0].cyc, 7);
      chk("t1_done_lat", done_cyc - lg[7].cyc, 1);
    end

    // mt=1 nt=3 kt=2, order k-i-j
    lg.delete();
    do_start(1, 3, 2, 1'b1);
    wait_done("t2_done_timeout", 40);
    chk("t2_hs", lg.size(), 6);
    if (lg.size() == 6) begin
      chk("t2_tuple2_j", lg[2].j, 8);
      chk("t2_tuple2_fk", int'(lg[2].fk), 1);
      chk("t2_tuple3_k", lg[3].k, 4);
      chk("t2_tuple3_fk", int'(lg[3].fk), 0);
      chk("t2_tuple3_lk", int'(lg[3].lk), 1);
      chk("t2_tuple0_lk", int'(lg[0].lk), 0);
    end

    // 4x4x4 with pseudo-random backpressure
    lg.delete();
    d0 = done_count;
    do_start(4, 4, 4, 1'b0);
    for (int n = 0; n < 2000 && done_count == d0; n++) begin
      idx_ready = 1'($urandom_range(0, 1));
      tick();
    end
    idx_ready = 1'b1;
    chk("t3_done_once", done_count - d0, 1);
    tick();
    tick();
    chk("t3_done_once_after", done_count - d0, 1);
    chk("t3_hs", lg.size(), 64);
    dups = 0;
    foreach (lg[n]) begin
      key = lg[n].i * 4096 + lg[n].j * 64 + lg[n].k;
      if (seen.exists(key)) dups++;
      seen[key] = 1;
    end
    chk("t3_dups", dups, 0);

    // illegal configurations
    v0 = valid_cycles;
    do_start(2, 2, 0, 1'b0);
    chk("t4_kt0_done", int'(done), 1);
    chk("t4_kt0_err", int'(err), 1);
    wait_done("t4_kt0_timeout", 2);
    do_start(MAXT + 1, 1, 1, 1'b1);
    chk("t4_mt17_err", int'(err), 1);
    wait_done("t4_mt17_timeout", 2);
    chk("t4_no_valid", valid_cycles - v0, 0);

    // abort after five handshakes
    lg.delete();
    d0 = done_count;
    do_start(2, 2, 2, 1'b0);
    for (int n = 0; n < 20 && hs_count < 0; n++) tick();
    while (lg.size() < 5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_valid_off", int'(idx_valid), 0);
    chk("t5_busy_off", int'(busy), 0);
    chk("t5_hs", lg.size(), 5);
    tick();
    chk("t5_no_done", done_count - d0, 0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("t5_abort_start_idle", int'(busy), 0);
    lg.delete();
    do_start(2, 2, 2, 1'b0);
    tick();
    chk("t5_restart_hs", lg.size() > 0, 1);
    if (lg.size() > 0) chk("t5_restart_origin", lg[0].i + lg[0].j + lg[0].k, 0);
    wait_done("t5_done_timeout", 40);

    // start ignored mid-run, then asynchronous reset mid-run
    d0 = done_count;
    idx_ready = 1'b0;
    do_start(3, 3, 3, 1'b0);
    idx_ready = 1'b1;
    tick();
    tick();
    start = 1'b1;
    cfg_mt = 5'd1; cfg_nt = 5'd1; cfg_kt = 5'd1;
    tick();
    start = 1'b0;
    tick();
    chk("t6_still_running", int'(idx_valid), 1);
    mon_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_outputs", int'({idx_valid, first_k, last_k, last, busy, done, err}), 0);
    chk("t6_rst_index", int'({index_i, index_j, index_k}), 0);
    #3;
    reset_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    repeat (3) tick();
    chk("t6_no_done", done_count - d0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t expected=finish", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
